// File: rtl/debounced_button_pio_if.sv
// Register-bus bundle for debounced_button_pio: select, write strobe/data,
// registered read data and the level interrupt.
interface debounced_button_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/debounced_button_pio.sv
// Debounced button parallel input port with edge capture and level interrupt.
// Inputs pass a two-flop synchroniser, then (optionally) a per-bit stable-count
// debouncer, then rise/fall edge detection into a write-1-to-clear capture reg.
// Optional feature macro: BUTTON_PIO_DEBOUNCE_EN enables the debounce counters;
// without it the debounced value is the synchronised value.
module debounced_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_port,
  debounced_button_pio_if.slave bus
);

  localparam logic [WIDTH-1:0] IDLE_V = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_cur;   // debounced value currently held
  logic [WIDTH-1:0] deb_next;  // debounced value after this edge
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise_ev, fall_ev, clr;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;

  // Per-bit stable counter: any agreeing cycle restarts it; the debounced bit
  // flips on the cycle the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state; reset discards any count in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q <= IDLE_V;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign deb_cur  = deb_q;
  assign deb_next = deb_d;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Second synchroniser stage doubles as the debounced value.
  assign deb_cur  = sync2_q;
  assign deb_next = sync1_q;
`endif

  // Edge events, control-register writes and read mux for the next edge.
  always_comb begin
    rise_ev    = deb_next & ~deb_cur & rise_en_q;
    fall_ev    = ~deb_next & deb_cur & fall_en_q;
    clr        = (wr_en && bus.address == 3'd3) ? wdata : '0;
    // Set after clear so an event coinciding with a clear is kept.
    edge_d     = (edge_q & ~clr) | rise_ev | fall_ev;
    irq_mask_d = (wr_en && bus.address == 3'd2) ? wdata : irq_mask_q;
    rise_en_d  = (wr_en && bus.address == 3'd4) ? wdata : rise_en_q;
    fall_en_d  = (wr_en && bus.address == 3'd5) ? wdata : fall_en_q;
    case (bus.address)
      3'd0:    readdata_d = 32'(deb_cur);
      3'd1:    readdata_d = 32'(sync2_q);
      3'd2:    readdata_d = 32'(irq_mask_q);
      3'd3:    readdata_d = 32'(edge_q);
      3'd4:    readdata_d = 32'(rise_en_q);
      3'd5:    readdata_d = 32'(fall_en_q);
      default: readdata_d = 32'd0;
    endcase
  end

  // Synchroniser, register file and read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= IDLE_V;
      sync2_q    <= IDLE_V;
      irq_mask_q <= '0;
      edge_q     <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '1;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      irq_mask_q <= irq_mask_d;
      edge_q     <= edge_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_q & irq_mask_q);

endmodule

// File: tb/tb_debounced_button_pio.sv
// Directed bench for debounced_button_pio (WIDTH=4, DEBOUNCE_CYCLES=8,
// IDLE_LEVEL=1); expectations follow BUTTON_PIO_DEBOUNCE_EN if defined.
module tb_debounced_button_pio;

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int          LAT = 10;
  localparam logic [3:0]  P1  = 4'hB;
`else
  localparam int          LAT = 2;
  localparam logic [3:0]  P1  = 4'h7;
`endif
  localparam logic [3:0] M1 = ~P1;          // bit that falls in the first test
  localparam logic [3:0] P2 = P1 & 4'hE;    // bit0 also low
  localparam logic [3:0] P3 = P2 & 4'hD;    // bit1 also low (press)
  localparam logic [3:0] P4 = ~P2;          // every bit toggles

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_port;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] rd;

  debounced_button_pio_if bus_if ();

  debounced_button_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(8), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    step();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    step();
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    in_port           = 4'hF;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    step(3);
    chk("rst_readdata", bus_if.readdata, 32'h0);
    chk("rst_irq", {31'd0, bus_if.irq}, 32'h0);
    reset = 1'b0;

    bus_rd(3'd0, rd); chk("rst_addr0", rd, 32'hF);
    bus_rd(3'd1, rd); chk("rst_addr1", rd, 32'hF);
    bus_rd(3'd2, rd); chk("rst_mask", rd, 32'h0);
    bus_rd(3'd3, rd); chk("rst_edge", rd, 32'h0);
    bus_rd(3'd4, rd); chk("rst_rise_en", rd, 32'h0);
    bus_rd(3'd5, rd); chk("rst_fall_en", rd, 32'hF);

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // Bounce: 5 low, 3 high, 5 low on bit0 never reaches 8 stable cycles.
    in_port = 4'hE; step(5);
    in_port = 4'hF; step(3);
    in_port = 4'hE; step(5);
    in_port = 4'hF; step(12);
    bus_rd(3'd0, rd); chk("bounce_addr0", rd, 32'hF);
    bus_rd(3'd3, rd); chk("bounce_edge", rd, 32'h0);
`endif

    // Clean fall on one bit: exact latency, capture and interrupt.
    bus_wr(3'd2, {28'd0, M1});
    chk("irq_masked_idle", {31'd0, bus_if.irq}, 32'h0);
    bus_if.address = 3'd0;
    in_port = P1;
    step(LAT - 1);
    chk("irq_before_lat", {31'd0, bus_if.irq}, 32'h0);
    step();
    chk("irq_at_lat", {31'd0, bus_if.irq}, 32'h1);
    chk("addr0_lag", bus_if.readdata, 32'hF);
    step();
    chk("addr0_new", bus_if.readdata, {28'd0, P1});
    bus_rd(3'd3, rd); chk("edge_first", rd, {28'd0, M1});
    bus_rd(3'd1, rd); chk("raw_first", rd, {28'd0, P1});
    bus_wr(3'd3, {28'd0, M1});
    chk("irq_cleared", {31'd0, bus_if.irq}, 32'h0);

    // Clear of bit0 lands in the same cycle as its falling event.
    in_port = P2;
    step(LAT - 1);
    bus_wr(3'd3, 32'h1);
    bus_rd(3'd3, rd); chk("set_beats_clear", rd, 32'h1);
    bus_wr(3'd3, 32'h1);
    bus_rd(3'd3, rd); chk("w1c_bit0", rd, 32'h0);

    // Rise-only enable on bit1: press ignored, release captured.
    bus_wr(3'd4, 32'h2);
    bus_wr(3'd5, 32'h0);
    in_port = P3; step(LAT + 2);
    bus_rd(3'd3, rd); chk("press_ignored", rd, 32'h0);
    in_port = P2; step(LAT + 2);
    bus_rd(3'd3, rd); chk("release_captured", rd, 32'h2);

    // All bits change together: independent captures.
    bus_wr(3'd4, 32'hF);
    bus_wr(3'd5, 32'hF);
    bus_wr(3'd3, 32'hF);
    in_port = P4; step(LAT + 2);
    bus_rd(3'd3, rd); chk("multi_edge", rd, 32'hF);
    bus_rd(3'd0, rd); chk("multi_addr0", rd, {28'd0, P4});
    chk("multi_irq", {31'd0, bus_if.irq}, 32'h1);

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // Counter boundary on bit0: 7 low samples rejected, 8 accepted.
    in_port = P4 & 4'hE; step(7);
    in_port = P4;        step(12);
    bus_rd(3'd0, rd); chk("dc_minus1_reject", rd, {28'd0, P4});
    in_port = P4 & 4'hE; step(8);
    in_port = P4;        step(2);
    bus_rd(3'd0, rd); chk("dc_exact_accept", rd, {28'd0, P4 & 4'hE});
    step(12);
    bus_rd(3'd0, rd); chk("dc_return", rd, {28'd0, P4});
`endif

    // Read-only / unused addresses, chipselect gating, upper data bits.
    bus_wr(3'd0, 32'h0);
    bus_rd(3'd0, rd); chk("ro_addr0", rd, {28'd0, P4});
    bus_wr(3'd1, 32'h0);
    bus_rd(3'd1, rd); chk("ro_addr1", rd, {28'd0, P4});
    bus_wr(3'd6, 32'hF);
    bus_rd(3'd6, rd); chk("addr6_zero", rd, 32'h0);
    bus_wr(3'd7, 32'hF);
    bus_rd(3'd7, rd); chk("addr7_zero", rd, 32'h0);
    bus_if.address    = 3'd2;
    bus_if.writedata  = 32'hF;
    bus_if.write_n    = 1'b0;
    bus_if.chipselect = 1'b0;
    step();
    bus_if.write_n = 1'b1;
    bus_rd(3'd2, rd); chk("no_cs_write", rd, {28'd0, M1});
    bus_wr(3'd4, 32'hFFFF_FFF0);
    bus_rd(3'd4, rd); chk("upper_bits_ignored", rd, 32'h0);

    // Asynchronous reset mid-operation, then a fresh full-latency change.
    bus_if.address = 3'd0;
    reset = 1'b1;
    #2;
    chk("midrst_readdata", bus_if.readdata, 32'h0);
    chk("midrst_irq", {31'd0, bus_if.irq}, 32'h0);
    step(2);
    reset = 1'b0;
    step(LAT);
    chk("postrst_lag", bus_if.readdata, 32'hF);
    step();
    chk("postrst_new", bus_if.readdata, {28'd0, P4});
    bus_rd(3'd2, rd); chk("postrst_mask", rd, 32'h0);
    bus_rd(3'd5, rd); chk("postrst_fall_en", rd, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
